// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//
// Steps the LED pattern peripheral through its pattern-select codes on a
// programmable period. A CPU configures it through an Avalon-MM slave, and
// it writes each code to the LED peripheral's data register (address 0)
// through an Avalon-MM master write port.
//
// Slave registers:
//   0 CTRL   bit0 RUN
//   1 PERIOD bits[PERIOD_W-1:0], a value of 0 behaves as 1
//   2 MASK   bits[2:0], bit i enables code 1<<i
//   3 STATUS bit0 busy, bits[2:1] step index, bit3 m_write (read-only)
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   address/chipselect/read/write    slave access strobes
//   writedata/readdata               slave data (readdata registered)
//   m_address/m_write/m_writedata    master write port (address fixed to 0)
//   m_waitrequest                    master stall from the LED peripheral
//
// Build option LED_SEQ_BLANK_ON_STOP_EN: clearing RUN issues one extra
// master write of code 0 (LEDs off) before the sequencer goes idle.
module led_pattern_sequencer #(
    parameter int unsigned PERIOD_W       = 24,
    parameter int unsigned DEFAULT_PERIOD = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_WRITE,
        S_COUNT
    } state_t;

    state_t              r_state;
    logic                r_run;
    logic [PERIOD_W-1:0] r_period;
    logic [2:0]          r_mask;
    logic [1:0]          r_idx;
    logic [PERIOD_W-1:0] r_count;
    logic                r_m_write;
    logic [31:0]         r_m_writedata;
    logic [31:0]         r_readdata;
`ifdef LED_SEQ_BLANK_ON_STOP_EN
    logic                r_blank;
`endif

    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_busy;
    logic [1:0]          w_status_idx;
    logic [31:0]         w_rd_mux;
    logic [1:0]          w_cand;
    logic                w_found;
    logic [1:0]          w_next_idx;
    logic [2:0]          w_code;
    logic [PERIOD_W-1:0] w_reload;
    logic                w_unused_wdata;

    assign w_wr_en        = chipselect & write;
    assign w_rd_en        = chipselect & read & ~write;
    assign w_busy         = (r_state != S_IDLE);
    // idx rests at 2 so the next search starts at bit 0; report 0 while idle
    assign w_status_idx   = w_busy ? r_idx : 2'd0;
    assign w_reload       = (r_period == '0) ? PERIOD_W'(1) : r_period;
    assign w_unused_wdata = &{1'b0, writedata};

    assign readdata    = r_readdata;
    assign m_address   = 2'b00;
    assign m_write     = r_m_write;
    assign m_writedata = r_m_writedata;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux = {31'd0, r_run};
            2'd1:    w_rd_mux = 32'(r_period);
            2'd2:    w_rd_mux = {29'd0, r_mask};
            default: w_rd_mux = {28'd0, r_m_write, w_status_idx, w_busy};
        endcase
    end

    // Round-robin search over idx+1, idx+2, idx+3 (mod 3)
    always_comb begin
        w_cand     = r_idx;
        w_found    = 1'b0;
        w_next_idx = r_idx;
        for (int unsigned k = 0; k < 3; k++) begin
            w_cand = (w_cand == 2'd2) ? 2'd0 : w_cand + 2'd1;
            if (!w_found && r_mask[w_cand]) begin
                w_found    = 1'b1;
                w_next_idx = w_cand;
            end
        end
        w_code = w_found ? (3'b001 << w_next_idx) : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_run         <= 1'b0;
            r_period      <= PERIOD_W'(DEFAULT_PERIOD);
            r_mask        <= 3'b111;
            r_idx         <= 2'd2;
            r_count       <= '0;
            r_m_write     <= 1'b0;
            r_m_writedata <= '0;
            r_readdata    <= '0;
`ifdef LED_SEQ_BLANK_ON_STOP_EN
            r_blank       <= 1'b0;
`endif
        end else begin
            // Slave port: write wins over read, readdata is 0 unless a read is accepted
            r_readdata <= '0;
            if (w_wr_en) begin
                case (address)
                    2'd0:    r_run    <= writedata[0];
                    2'd1:    r_period <= writedata[PERIOD_W-1:0];
                    2'd2:    r_mask   <= writedata[2:0];
                    default: ;
                endcase
            end else if (w_rd_en) begin
                r_readdata <= w_rd_mux;
            end

            case (r_state)
                S_IDLE: begin
                    r_m_write <= 1'b0;
`ifdef LED_SEQ_BLANK_ON_STOP_EN
                    r_blank   <= 1'b0;
`endif
                    if (w_wr_en && address == 2'd0 && writedata[0])
                        r_state <= S_SELECT;
                end

                S_SELECT: begin
                    r_m_write <= 1'b1;
                    r_state   <= S_WRITE;
`ifdef LED_SEQ_BLANK_ON_STOP_EN
                    if (!r_run) begin
                        r_blank       <= 1'b1;
                        r_m_writedata <= '0;
                    end else begin
                        r_idx         <= w_next_idx;
                        r_m_writedata <= {29'd0, w_code};
                    end
`else
                    r_idx         <= w_next_idx;
                    r_m_writedata <= {29'd0, w_code};
`endif
                end

                S_WRITE: begin
                    if (!m_waitrequest) begin
`ifdef LED_SEQ_BLANK_ON_STOP_EN
                        if (r_blank) begin
                            r_m_write <= 1'b0;
                            r_state   <= S_IDLE;
                        end else if (!r_run) begin
                            // pending code accepted; stay in WRITE for the blank
                            r_blank       <= 1'b1;
                            r_m_writedata <= '0;
                        end else begin
                            r_m_write <= 1'b0;
                            r_count   <= w_reload;
                            r_state   <= S_COUNT;
                        end
`else
                        r_m_write <= 1'b0;
                        if (r_run) begin
                            r_count <= w_reload;
                            r_state <= S_COUNT;
                        end else begin
                            r_state <= S_IDLE;
                        end
`endif
                    end
                end

                default: begin // S_COUNT
                    if (!r_run) begin
`ifdef LED_SEQ_BLANK_ON_STOP_EN
                        r_blank       <= 1'b1;
                        r_m_write     <= 1'b1;
                        r_m_writedata <= '0;
                        r_state       <= S_WRITE;
`else
                        r_state <= S_IDLE;
`endif
                    end else if (r_count == PERIOD_W'(1)) begin
                        r_state <= S_SELECT;
                    end else begin
                        r_count <= r_count - PERIOD_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dummy;
    logic [31:0] acc_code[$];
    int          acc_cyc[$];

    led_pattern_sequencer #(
        .PERIOD_W      (24),
        .DEFAULT_PERIOD(5000000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .m_address    (m_address),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record each master write that the next edge will accept
    always @(negedge clk) begin
        if (!reset && m_write && !m_waitrequest) begin
            acc_code.push_back(m_writedata);
            acc_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        acc_code.delete();
        acc_cyc.delete();
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d, output int at_cyc);
        @(posedge clk); #1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        at_cyc = cyc;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (acc_code.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (acc_code.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d accepts, required %0d", name, acc_code.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_rd [4];
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd5000000; exp_rd[2] = 32'd7; exp_rd[3] = 32'd0;
        do_reset();
        checks++;
        if (m_write !== 1'b0 || m_writedata !== 32'd0 || readdata !== 32'd0 || m_address !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got m_write=%b m_writedata=%0h readdata=%0h m_address=%0d, required all 0",
                     m_write, m_writedata, readdata, m_address);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_read(2'(i), d);
            checks++;
            if (d !== exp_rd[i]) begin
                errors++;
                $display("FAIL reset_reg%0d: got %0h required %0h", i, d, exp_rd[i]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL readdata_idle: got %0h required 0", readdata);
        end
    endtask

    task automatic test_sequence();
        int n;
        logic [31:0] d;
        logic [31:0] exp_code [4];
        exp_code[0] = 32'd1; exp_code[1] = 32'd2; exp_code[2] = 32'd4; exp_code[3] = 32'd1;
        do_reset();
        cpu_write(2'd1, 32'd4, dummy);
        cpu_write(2'd2, 32'd7, dummy);
        cpu_read(2'd1, d);
        checks++;
        if (d !== 32'd4) begin
            errors++;
            $display("FAIL period_readback: got %0h required 4", d);
        end
        cpu_write(2'd0, 32'd1, n);
        wait_acc(4, 60, "seq");
        if (acc_code.size() >= 4) begin
            checks++;
            if (acc_cyc[0] !== n + 2) begin
                errors++;
                $display("FAIL first_write_latency: got %0d cycles required 2", acc_cyc[0] - n);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_code[i] !== exp_code[i]) begin
                    errors++;
                    $display("FAIL seq_code%0d: got %0h required %0h", i, acc_code[i], exp_code[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
                    errors++;
                    $display("FAIL seq_spacing%0d: got %0d required 6", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        logic [31:0] exp_code [4];
        exp_code[0] = 32'd1; exp_code[1] = 32'd4; exp_code[2] = 32'd1; exp_code[3] = 32'd4;
        do_reset();
        cpu_write(2'd1, 32'd1, dummy);
        cpu_write(2'd2, 32'd5, dummy);
        cpu_write(2'd0, 32'd1, dummy);
        wait_acc(4, 40, "mask101");
        if (acc_code.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_code[i] !== exp_code[i]) begin
                    errors++;
                    $display("FAIL mask101_code%0d: got %0h required %0h", i, acc_code[i], exp_code[i]);
                end
            end
            checks++;
            if (acc_cyc[1] - acc_cyc[0] !== 3) begin
                errors++;
                $display("FAIL mask101_spacing: got %0d required 3", acc_cyc[1] - acc_cyc[0]);
            end
        end

        do_reset();
        cpu_write(2'd1, 32'd1, dummy);
        cpu_write(2'd2, 32'd0, dummy);
        cpu_write(2'd0, 32'd1, dummy);
        wait_acc(3, 40, "mask0");
        if (acc_code.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_code[i] !== 32'd0) begin
                    errors++;
                    $display("FAIL mask0_code%0d: got %0h required 0", i, acc_code[i]);
                end
            end
        end
        // busy=1, idx still 2 with an empty mask
        cpu_read(2'd3, d);
        checks++;
        if ((d & 32'd7) !== 32'd5) begin
            errors++;
            $display("FAIL mask0_status: got %0h required 5 in bits[2:0]", d & 32'd7);
        end
    endtask

    task automatic test_period_zero();
        logic [31:0] d;
        do_reset();
        cpu_write(2'd1, 32'd0, dummy);
        cpu_write(2'd0, 32'd1, dummy);
        wait_acc(3, 40, "period0");
        if (acc_code.size() >= 3) begin
            checks++;
            if (acc_cyc[2] - acc_cyc[1] !== 3 || acc_cyc[1] - acc_cyc[0] !== 3) begin
                errors++;
                $display("FAIL period0_spacing: got %0d,%0d required 3,3",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
        cpu_read(2'd1, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL period0_readback: got %0h required 0", d);
        end
    endtask

    task automatic test_stall_stop();
        int k;
        logic [31:0] d;
        do_reset();
        cpu_write(2'd1, 32'd2, dummy);
        m_waitrequest = 1'b1;
        cpu_write(2'd0, 32'd1, dummy);
        k = 0;
        while (m_write !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (m_write !== 1'b1) begin
            errors++;
            $display("FAIL stall_wait: got m_write=%b required 1", m_write);
        end
        cpu_write(2'd0, 32'd0, dummy);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (m_write !== 1'b1 || m_writedata !== 32'd1) begin
                errors++;
                $display("FAIL stall_hold%0d: got m_write=%b data=%0h required 1/1", i, m_write, m_writedata);
            end
        end
        acc_code.delete();
        acc_cyc.delete();
        @(posedge clk); #1;
        m_waitrequest = 1'b0;
        repeat (6) @(posedge clk);
        #1;
`ifdef LED_SEQ_BLANK_ON_STOP_EN
        checks++;
        if (acc_code.size() !== 2) begin
            errors++;
            $display("FAIL stop_accepts: got %0d required 2", acc_code.size());
        end else begin
            checks++;
            if (acc_code[0] !== 32'd1 || acc_code[1] !== 32'd0) begin
                errors++;
                $display("FAIL stop_codes: got %0h,%0h required 1,0", acc_code[0], acc_code[1]);
            end
        end
`else
        checks++;
        if (acc_code.size() !== 1) begin
            errors++;
            $display("FAIL stop_accepts: got %0d required 1", acc_code.size());
        end else begin
            checks++;
            if (acc_code[0] !== 32'd1) begin
                errors++;
                $display("FAIL stop_code: got %0h required 1", acc_code[0]);
            end
        end
`endif
        cpu_read(2'd3, d);
        checks++;
        if (d !== 32'd0 || m_write !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: got status=%0h m_write=%b required 0/0", d, m_write);
        end
    endtask

    task automatic test_reset_midwrite();
        int k;
        logic [31:0] d;
        do_reset();
        cpu_write(2'd1, 32'd3, dummy);
        m_waitrequest = 1'b1;
        cpu_write(2'd0, 32'd1, dummy);
        k = 0;
        while (m_write !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (m_write !== 1'b0 || m_writedata !== 32'd0) begin
            errors++;
            $display("FAIL reset_midwrite: got m_write=%b data=%0h required 0/0", m_write, m_writedata);
        end
        reset = 1'b0;
        m_waitrequest = 1'b0;
        cpu_read(2'd3, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_status: got %0h required 0", d);
        end
        cpu_read(2'd1, d);
        checks++;
        if (d !== 32'd5000000) begin
            errors++;
            $display("FAIL reset_period: got %0h required %0h", d, 32'd5000000);
        end
    endtask

    task automatic test_rw_collision();
        logic [31:0] d;
        do_reset();
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 2'd1; writedata = 32'd9;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL collision_readdata: got %0h required 0", readdata);
        end
        cpu_read(2'd1, d);
        checks++;
        if (d !== 32'd9) begin
            errors++;
            $display("FAIL collision_period: got %0h required 9", d);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_mask();
        test_period_zero();
        test_stall_stop();
        test_reset_midwrite();
        test_rw_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
